// File: rtl/noc_c2_out_arbiter.sv
// Round-robin arbiter sharing the cluster-2 output link between the C1 and P sources,
// with a single-entry registered output buffer and saturating per-source packet counters.
module noc_c2_out_arbiter #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned CNTW  = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             c1_valid_i,
    input  logic [WIDTH-1:0] c1_data_i,
    output logic             c1_ready_o,
    input  logic             p_valid_i,
    input  logic [WIDTH-1:0] p_data_i,
    output logic             p_ready_o,
    output logic             out_valid_o,
    output logic [WIDTH-1:0] out_data_o,
    output logic             out_src_o,
    input  logic             out_ready_i,
    output logic [CNTW-1:0]  c1_cnt_o,
    output logic [CNTW-1:0]  p_cnt_o
);

    localparam logic SrcC1 = 1'b0;
    localparam logic SrcP  = 1'b1;

    typedef enum logic {StEmpty, StFull} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             src_q, src_d;
    logic             last_grant_q, last_grant_d;
    logic [CNTW-1:0]  c1_cnt_q, c1_cnt_d;
    logic [CNTW-1:0]  p_cnt_q, p_cnt_d;

    logic gnt_valid;
    logic gnt_src;
    logic can_accept;
    logic accept;

    // On contention the source that did not win the last accepted transfer goes next.
    always_comb begin
        gnt_valid = c1_valid_i | p_valid_i;
        if (c1_valid_i && p_valid_i) begin
            gnt_src = ~last_grant_q;
        end else begin
            gnt_src = p_valid_i ? SrcP : SrcC1;
        end
    end

    // A FULL buffer that drains this cycle may refill in the same cycle.
    assign can_accept = (state_q == StEmpty) | out_ready_i;
    assign accept     = can_accept & gnt_valid;

    assign c1_ready_o = accept & (gnt_src == SrcC1);
    assign p_ready_o  = accept & (gnt_src == SrcP);

    always_comb begin
        state_d      = state_q;
        data_d       = data_q;
        src_d        = src_q;
        last_grant_d = last_grant_q;
        c1_cnt_d     = c1_cnt_q;
        p_cnt_d      = p_cnt_q;

        unique case (state_q)
            StEmpty: begin
                if (accept) begin
                    state_d = StFull;
                end
            end
            StFull: begin
                if (accept) begin
                    state_d = StFull;
                end else if (out_ready_i) begin
                    state_d = StEmpty;
                end
            end
            default: state_d = StEmpty;
        endcase

        if (accept) begin
            data_d       = (gnt_src == SrcP) ? p_data_i : c1_data_i;
            src_d        = gnt_src;
            last_grant_d = gnt_src;
            if (gnt_src == SrcC1) begin
                if (c1_cnt_q != {CNTW{1'b1}}) begin
                    c1_cnt_d = c1_cnt_q + CNTW'(1);
                end
            end else begin
                if (p_cnt_q != {CNTW{1'b1}}) begin
                    p_cnt_d = p_cnt_q + CNTW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= StEmpty;
            data_q       <= '0;
            src_q        <= SrcC1;
            last_grant_q <= SrcP;
            c1_cnt_q     <= '0;
            p_cnt_q      <= '0;
        end else begin
            state_q      <= state_d;
            data_q       <= data_d;
            src_q        <= src_d;
            last_grant_q <= last_grant_d;
            c1_cnt_q     <= c1_cnt_d;
            p_cnt_q      <= p_cnt_d;
        end
    end

    assign out_valid_o = (state_q == StFull);
    assign out_data_o  = data_q;
    assign out_src_o   = src_q;
    assign c1_cnt_o    = c1_cnt_q;
    assign p_cnt_o     = p_cnt_q;

endmodule

// File: tb/tb_noc_c2_out_arbiter.sv
// Directed bench for noc_c2_out_arbiter; a second instance with 2-bit counters covers saturation.
module tb_noc_c2_out_arbiter;

    logic        clk;
    logic        reset;
    logic        c1_valid;
    logic [15:0] c1_data;
    logic        p_valid;
    logic [15:0] p_data;
    logic        out_ready;

    logic        c1_ready, p_ready, out_valid, out_src;
    logic [15:0] out_data;
    logic [7:0]  c1_cnt, p_cnt;

    logic        c1_ready2, p_ready2, out_valid2, out_src2;
    logic [15:0] out_data2;
    logic [1:0]  c1_cnt2, p_cnt2;

    int tests = 0;
    int fails = 0;

    noc_c2_out_arbiter #(.WIDTH(16), .CNTW(8)) dut (
        .clk         (clk),
        .reset       (reset),
        .c1_valid_i  (c1_valid),
        .c1_data_i   (c1_data),
        .c1_ready_o  (c1_ready),
        .p_valid_i   (p_valid),
        .p_data_i    (p_data),
        .p_ready_o   (p_ready),
        .out_valid_o (out_valid),
        .out_data_o  (out_data),
        .out_src_o   (out_src),
        .out_ready_i (out_ready),
        .c1_cnt_o    (c1_cnt),
        .p_cnt_o     (p_cnt)
    );

    noc_c2_out_arbiter #(.WIDTH(16), .CNTW(2)) dut2 (
        .clk         (clk),
        .reset       (reset),
        .c1_valid_i  (c1_valid),
        .c1_data_i   (c1_data),
        .c1_ready_o  (c1_ready2),
        .p_valid_i   (p_valid),
        .p_data_i    (p_data),
        .p_ready_o   (p_ready2),
        .out_valid_o (out_valid2),
        .out_data_o  (out_data2),
        .out_src_o   (out_src2),
        .out_ready_i (out_ready),
        .c1_cnt_o    (c1_cnt2),
        .p_cnt_o     (p_cnt2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic edge_settle();
        @(posedge clk);
        #1;
    endtask

    task automatic rst_pulse();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        int ci;
        int pi;
        logic        exp_src;
        logic [15:0] exp_data;

        reset     = 1'b1;
        c1_valid  = 1'b0;
        c1_data   = '0;
        p_valid   = 1'b0;
        p_data    = '0;
        out_ready = 1'b0;

        #2;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", 32'(out_data), 32'h0);
        check("rst_out_src", 32'(out_src), 32'd0);
        check("rst_c1_cnt", 32'(c1_cnt), 32'd0);
        check("rst_p_cnt", 32'(p_cnt), 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // Test 1: single C1 packet.
        c1_valid  = 1'b1;
        c1_data   = 16'h1234;
        out_ready = 1'b1;
        #1;
        check("t1_c1_ready", 32'(c1_ready), 32'd1);
        check("t1_p_ready", 32'(p_ready), 32'd0);
        edge_settle();
        check("t1_out_valid", 32'(out_valid), 32'd1);
        check("t1_out_data", 32'(out_data), 32'h1234);
        check("t1_out_src", 32'(out_src), 32'd0);
        check("t1_c1_cnt", 32'(c1_cnt), 32'd1);
        @(negedge clk);
        c1_valid = 1'b0;
        reset    = 1'b1;
        #1;
        check("t1_async_rst_valid", 32'(out_valid), 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // Test 2: both sources streaming, alternation starting with C1.
        ci = 0;
        pi = 0;
        for (int i = 0; i < 4; i++) begin
            c1_valid = 1'b1;
            p_valid  = 1'b1;
            c1_data  = 16'hA001 + 16'(ci);
            p_data   = 16'hB001 + 16'(pi);
            exp_src  = (i % 2 == 1);
            exp_data = exp_src ? (16'hB001 + 16'(pi)) : (16'hA001 + 16'(ci));
            #1;
            check("t2_c1_ready", 32'(c1_ready), 32'(!exp_src));
            check("t2_p_ready", 32'(p_ready), 32'(exp_src));
            edge_settle();
            check("t2_out_valid", 32'(out_valid), 32'd1);
            check("t2_out_data", 32'(out_data), 32'(exp_data));
            check("t2_out_src", 32'(out_src), 32'(exp_src));
            if (exp_src) pi++;
            else ci++;
            @(negedge clk);
        end
        check("t2_c1_cnt", 32'(c1_cnt), 32'd2);
        check("t2_p_cnt", 32'(p_cnt), 32'd2);

        // Test 3: stall with buffer FULL and both valid; priority must not rotate.
        c1_data   = 16'hA003;
        p_data    = 16'hB003;
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            check("t3_stall_c1_ready", 32'(c1_ready), 32'd0);
            check("t3_stall_p_ready", 32'(p_ready), 32'd0);
            edge_settle();
            check("t3_stall_out_data", 32'(out_data), 32'hB002);
            check("t3_stall_out_valid", 32'(out_valid), 32'd1);
            @(negedge clk);
        end
        out_ready = 1'b1;
        #1;
        check("t3_release_c1_ready", 32'(c1_ready), 32'd1);
        check("t3_release_p_ready", 32'(p_ready), 32'd0);
        edge_settle();
        check("t3_release_out_data", 32'(out_data), 32'hA003);
        @(negedge clk);
        c1_valid = 1'b0;
        #1;
        check("t3_p_ready", 32'(p_ready), 32'd1);
        edge_settle();
        check("t3_out_data_p", 32'(out_data), 32'hB003);
        check("t3_p_cnt", 32'(p_cnt), 32'd3);
        @(negedge clk);
        p_valid = 1'b0;
        edge_settle();
        check("t3_drain_empty", 32'(out_valid), 32'd0);
        check("t3_c1_cnt", 32'(c1_cnt), 32'd3);

        rst_pulse();

        // Test 4: P only for three packets, then contention goes to C1.
        for (int k = 0; k < 3; k++) begin
            p_valid = 1'b1;
            p_data  = 16'hC001 + 16'(k);
            #1;
            check("t4_p_ready", 32'(p_ready), 32'd1);
            check("t4_c1_ready", 32'(c1_ready), 32'd0);
            edge_settle();
            check("t4_p_cnt", 32'(p_cnt), 32'(k + 1));
            check("t4_out_src", 32'(out_src), 32'd1);
            @(negedge clk);
        end
        c1_valid = 1'b1;
        c1_data  = 16'hD001;
        #1;
        check("t4_both_c1_ready", 32'(c1_ready), 32'd1);
        check("t4_both_p_ready", 32'(p_ready), 32'd0);
        edge_settle();
        check("t4_out_data", 32'(out_data), 32'hD001);
        check("t4_out_src_c1", 32'(out_src), 32'd0);
        check("t4_c1_cnt", 32'(c1_cnt), 32'd1);
        check("t4_p_cnt_final", 32'(p_cnt), 32'd3);

        // Test 5: asynchronous reset while FULL and stalled.
        @(negedge clk);
        out_ready = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        check("t5_out_valid", 32'(out_valid), 32'd0);
        check("t5_out_data", 32'(out_data), 32'h0);
        check("t5_c1_cnt", 32'(c1_cnt), 32'd0);
        check("t5_p_cnt", 32'(p_cnt), 32'd0);
        @(negedge clk);
        reset     = 1'b0;
        out_ready = 1'b1;
        #1;
        check("t5_post_c1_ready", 32'(c1_ready), 32'd1);
        check("t5_post_p_ready", 32'(p_ready), 32'd0);
        edge_settle();
        check("t5_post_out_src", 32'(out_src), 32'd0);

        rst_pulse();

        // Test 6: 2-bit counter saturates at 3, 8-bit counter keeps counting.
        p_valid = 1'b0;
        for (int k = 0; k < 5; k++) begin
            c1_valid = 1'b1;
            c1_data  = 16'hE001 + 16'(k);
            edge_settle();
            check("t6_sat_c1_cnt", 32'(c1_cnt2), (k < 2) ? 32'(k + 1) : 32'd3);
            check("t6_wide_c1_cnt", 32'(c1_cnt), 32'(k + 1));
            check("t6_out_data", 32'(out_data2), 32'(16'hE001 + 16'(k)));
            @(negedge clk);
        end
        c1_valid = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
